// File: rtl/pianista_pkg.sv
// Shared encodings for the WASDE navigation and playback sequencer.
// Holds state/mode codes, key bit positions and the key-event priority picker.
package pianista_pkg;

    typedef enum logic [1:0] {
        ST_BROWSE  = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_FREE  = 2'd0;
    localparam logic [1:0] MODE_AUTO  = 2'd1;
    localparam logic [1:0] MODE_LEARN = 2'd2;

    localparam int unsigned NUM_KEYS = 5;
    localparam int unsigned KEY_W    = 4;
    localparam int unsigned KEY_A    = 3;
    localparam int unsigned KEY_S    = 2;
    localparam int unsigned KEY_D    = 1;
    localparam int unsigned KEY_E    = 0;

    typedef enum logic [2:0] {
        EV_NONE = 3'd0,
        EV_E    = 3'd1,
        EV_W    = 3'd2,
        EV_S    = 3'd3,
        EV_A    = 3'd4,
        EV_D    = 3'd5
    } key_ev_t;

    // Single winning event when several keys fire together: E > W > S > A > D.
    function automatic key_ev_t pick_event(input logic [NUM_KEYS-1:0] press);
        key_ev_t ev;
        ev = EV_NONE;
        if (press[KEY_E])      ev = EV_E;
        else if (press[KEY_W]) ev = EV_W;
        else if (press[KEY_S]) ev = EV_S;
        else if (press[KEY_A]) ev = EV_A;
        else if (press[KEY_D]) ev = EV_D;
        return ev;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: accepts a level change after DEB_CYCLES consecutive
// differing samples and emits a one-cycle press on each accepted rising edge.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (raw != level_q) begin
            // The DEB_CYCLES-th differing sample flips the level.
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = raw;
                press_d = raw;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/song_select_ctrl.sv
// Browse/play/pause sequencer driven by debounced WASDE presses; selects the
// song and mode and issues registered start/stop pulses to the player.
module song_select_ctrl
    import pianista_pkg::*;
#(
    parameter int unsigned NUM_SONGS  = 8,
    parameter int unsigned NUM_MODES  = 3,
    parameter int unsigned DEB_CYCLES = 1_000_000,
    localparam int unsigned SW        = $clog2(NUM_SONGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] wasde_signal,
    input  logic                play_done,
    output logic [SW-1:0]       song_idx,
    output logic [1:0]          mode,
    output logic                play_start,
    output logic                play_stop,
    output logic                paused,
    output logic [1:0]          state
);

    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_evt;
    key_ev_t             ev;

    for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_deb
        key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (wasde_signal[g]),
            .level(key_level[g]),
            .press(key_press[g])
        );
    end

    // A press is only honoured while its debounced level is still high.
    assign key_evt = key_press & key_level;

    always_comb begin
        ev = pick_event(key_evt);
    end

    state_t        state_q, state_d;
    logic [SW-1:0] song_idx_q, song_idx_d;
    logic [1:0]    mode_q, mode_d;
    logic          play_start_q, play_start_d;
    logic          play_stop_q, play_stop_d;
    logic          paused_q, paused_d;

    logic [SW-1:0] idx_inc, idx_dec;
    logic [1:0]    mode_inc, mode_dec;

    always_comb begin
        idx_inc  = (song_idx_q == SW'(NUM_SONGS - 1)) ? '0 : song_idx_q + SW'(1);
        idx_dec  = (song_idx_q == '0) ? SW'(NUM_SONGS - 1) : song_idx_q - SW'(1);
        mode_inc = (mode_q == 2'(NUM_MODES - 1)) ? 2'd0 : mode_q + 2'd1;
        mode_dec = (mode_q == 2'd0) ? 2'(NUM_MODES - 1) : mode_q - 2'd1;
    end

    always_comb begin
        state_d      = state_q;
        song_idx_d   = song_idx_q;
        mode_d       = mode_q;
        play_start_d = 1'b0;
        play_stop_d  = 1'b0;

        unique case (state_q)
            ST_BROWSE: begin
                unique case (ev)
                    EV_E: begin
                        play_start_d = 1'b1;
                        state_d      = ST_PLAYING;
                    end
                    EV_W:    song_idx_d = idx_dec;
                    EV_S:    song_idx_d = idx_inc;
                    EV_A:    mode_d     = mode_dec;
                    EV_D:    mode_d     = mode_inc;
                    default: ;
                endcase
            end
            ST_PLAYING: begin
                // End-of-song takes precedence over any key in the same cycle.
                if (play_done) begin
                    if (mode_q == MODE_AUTO) begin
                        song_idx_d   = idx_inc;
                        play_start_d = 1'b1;
                    end else begin
                        state_d = ST_BROWSE;
                    end
                end else if (ev == EV_E) begin
                    state_d = ST_PAUSED;
                end else if (ev == EV_W || ev == EV_S) begin
                    play_stop_d = 1'b1;
                    state_d     = ST_BROWSE;
                end
            end
            ST_PAUSED: begin
                if (ev == EV_E) begin
                    state_d = ST_PLAYING;
                end else if (ev == EV_W || ev == EV_S) begin
                    play_stop_d = 1'b1;
                    state_d     = ST_BROWSE;
                end
            end
            default: state_d = ST_BROWSE;
        endcase

        paused_d = (state_d == ST_PAUSED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BROWSE;
            song_idx_q   <= '0;
            mode_q       <= MODE_FREE;
            play_start_q <= 1'b0;
            play_stop_q  <= 1'b0;
            paused_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            song_idx_q   <= song_idx_d;
            mode_q       <= mode_d;
            play_start_q <= play_start_d;
            play_stop_q  <= play_stop_d;
            paused_q     <= paused_d;
        end
    end

    assign song_idx   = song_idx_q;
    assign mode       = mode_q;
    assign play_start = play_start_q;
    assign play_stop  = play_stop_q;
    assign paused     = paused_q;
    assign state      = state_q;

endmodule

// File: tb/tb_song_select_ctrl.sv
// Directed bench for song_select_ctrl with a cycle model of the key rules
// compared every cycle, plus literal expectations at each scenario step.
module tb_song_select_ctrl;

    localparam int unsigned NS  = 8;
    localparam int unsigned NM  = 3;
    localparam int unsigned DEB = 4;
    localparam int KW = 4, KA = 3, KS = 2, KD = 1, KE = 0;

    logic       clk;
    logic       rst;
    logic [4:0] wasde_signal;
    logic       play_done;
    logic [2:0] song_idx;
    logic [1:0] mode;
    logic       play_start;
    logic       play_stop;
    logic       paused;
    logic [1:0] state;

    song_select_ctrl #(
        .NUM_SONGS (NS),
        .NUM_MODES (NM),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wasde_signal(wasde_signal),
        .play_done   (play_done),
        .song_idx    (song_idx),
        .mode        (mode),
        .play_start  (play_start),
        .play_stop   (play_stop),
        .paused      (paused),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a key's level flips once its last DEB raw samples all
    // disagree with it; menu behaviour uses modular arithmetic on integers.
    logic [DEB-1:0] m_hist [5];
    logic [4:0]     m_lvl;
    logic [4:0]     m_press;
    int m_state, m_idx, m_mode;
    bit m_start, m_stop;
    int prio [5] = '{KE, KW, KS, KA, KD};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 5; k++) m_hist[k] = '0;
            m_lvl = '0; m_press = '0;
            m_state = 0; m_idx = 0; m_mode = 0;
            m_start = 0; m_stop = 0;
        end else begin
            int win;
            win = -1;
            for (int i = 0; i < 5; i++)
                if (win < 0 && m_press[prio[i]]) win = prio[i];
            m_start = 0;
            m_stop  = 0;
            case (m_state)
                0: begin
                    if (win == KE) begin m_start = 1; m_state = 1; end
                    else if (win == KW) m_idx  = (m_idx + NS - 1) % NS;
                    else if (win == KS) m_idx  = (m_idx + 1) % NS;
                    else if (win == KA) m_mode = (m_mode + NM - 1) % NM;
                    else if (win == KD) m_mode = (m_mode + 1) % NM;
                end
                1: begin
                    if (play_done) begin
                        if (m_mode == 1) begin m_idx = (m_idx + 1) % NS; m_start = 1; end
                        else m_state = 0;
                    end else if (win == KE) m_state = 2;
                    else if (win == KW || win == KS) begin m_stop = 1; m_state = 0; end
                end
                default: begin
                    if (win == KE) m_state = 1;
                    else if (win == KW || win == KS) begin m_stop = 1; m_state = 0; end
                end
            endcase
            for (int k = 0; k < 5; k++) begin
                m_hist[k] = {m_hist[k][DEB-2:0], wasde_signal[k]};
                m_press[k] = 1'b0;
                if (m_hist[k] == {DEB{~m_lvl[k]}}) begin
                    m_lvl[k]   = ~m_lvl[k];
                    m_press[k] = m_lvl[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("song_idx", int'(song_idx), m_idx);
            chk("mode", int'(mode), m_mode);
            chk("state", int'(state), m_state);
            chk("paused", int'(paused), int'(m_state == 2));
            chk("play_start", int'(play_start), int'(m_start));
            chk("play_stop", int'(play_stop), int'(m_stop));
            chk("start_stop_excl", int'(play_start & play_stop), 0);
            if (play_start) start_cnt++;
            if (play_stop)  stop_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic tap(input int k);
        wasde_signal[k] = 1'b1;
        step(DEB + 2);
        wasde_signal[k] = 1'b0;
        step(8);
    endtask

    int s0, p0;

    initial begin
        rst = 1'b0; wasde_signal = '0; play_done = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_idx", int'(song_idx), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_start", int'(play_start), 0);
        chk("rst_stop", int'(play_stop), 0);
        step(2);
        rst = 1'b0;
        chk_en = 1'b1;

        // Short bounce on S is filtered.
        wasde_signal[KS] = 1'b1; step(3); wasde_signal[KS] = 1'b0; step(8);
        chk("bounce_idx", int'(song_idx), 0);

        // Held S: update lands on the fifth edge, once only.
        wasde_signal[KS] = 1'b1;
        step(4); chk("hold_edge4", int'(song_idx), 0);
        step(1); chk("hold_edge5", int'(song_idx), 1);
        step(95); chk("hold_100", int'(song_idx), 1);
        wasde_signal[KS] = 1'b0; step(8);

        tap(KW); chk("w_1to0", int'(song_idx), 0);
        tap(KW); chk("w_wrap", int'(song_idx), 7);
        tap(KS); chk("s_wrap", int'(song_idx), 0);
        tap(KD); chk("d_1", int'(mode), 1);
        tap(KD); chk("d_2", int'(mode), 2);
        tap(KD); chk("d_wrap", int'(mode), 0);
        tap(KA); chk("a_wrap", int'(mode), 2);
        tap(KD); chk("d_free", int'(mode), 0);

        // Play / pause / resume / stop.
        s0 = start_cnt; p0 = stop_cnt;
        tap(KE); chk("play_state", int'(state), 1); chk("play_start_cnt", start_cnt, s0 + 1);
        tap(KE); chk("pause_state", int'(state), 2); chk("pause_lvl", int'(paused), 1);
        tap(KE); chk("resume_state", int'(state), 1); chk("resume_nostart", start_cnt, s0 + 1);
        tap(KS); chk("stop_state", int'(state), 0); chk("stop_cnt", stop_cnt, p0 + 1);
        chk("stop_idx", int'(song_idx), 0);

        // AUTO advance with wrap on play_done.
        tap(KD); tap(KW);
        chk("auto_mode", int'(mode), 1); chk("auto_idx7", int'(song_idx), 7);
        tap(KE);
        s0 = start_cnt;
        play_done = 1'b1; step(1); play_done = 1'b0;
        chk("auto_idx_wrap", int'(song_idx), 0);
        chk("auto_state", int'(state), 1);
        step(1); chk("auto_start", start_cnt, s0 + 1);
        tap(KS); tap(KA);
        chk("free_mode", int'(mode), 0);
        tap(KE);
        s0 = start_cnt; p0 = stop_cnt;
        play_done = 1'b1; step(1); play_done = 1'b0; step(1);
        chk("free_done_state", int'(state), 0);
        chk("free_done_nostart", start_cnt, s0);
        chk("free_done_nostop", stop_cnt, p0);

        // E and S in the same cycle: E wins.
        s0 = start_cnt;
        wasde_signal[KE] = 1'b1; wasde_signal[KS] = 1'b1;
        step(DEB + 2);
        wasde_signal[KE] = 1'b0; wasde_signal[KS] = 1'b0;
        step(8);
        chk("sim_state", int'(state), 1);
        chk("sim_idx", int'(song_idx), 0);
        chk("sim_start", start_cnt, s0 + 1);

        // play_done lands in the same cycle as the E event.
        wasde_signal[KE] = 1'b1;
        step(4); play_done = 1'b1; step(1); play_done = 1'b0;
        chk("coinc_state", int'(state), 0);
        chk("coinc_paused", int'(paused), 0);
        wasde_signal[KE] = 1'b0; step(8);

        // Async reset mid-playback, then W held through reset release.
        tap(KS); tap(KS);
        tap(KE);
        chk("pre_rst_state", int'(state), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_idx", int'(song_idx), 0);
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_paused", int'(paused), 0);
        chk("mid_rst_stop", int'(play_stop), 0);
        wasde_signal[KW] = 1'b1;
        step(2);
        rst = 1'b0;
        step(4); chk("held_rst_edge4", int'(song_idx), 0);
        step(1); chk("held_rst_edge5", int'(song_idx), 7);
        wasde_signal[KW] = 1'b0; step(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_select_ctrl.md
# song_select_ctrl

Menu and playback sequencer for the five navigation keys (W, A, S, D, E). It sits directly behind the registered WASDE key stage. Each key is debounced and converted into a single-cycle press event. The events drive a three-state browse/play/pause FSM that selects the song index and play mode and issues start/stop commands to the song player.

## Interface
- NUM_SONGS, 8, number of selectable songs (≥2); SW = $clog2(NUM_SONGS)
- NUM_MODES, 3, number of play modes (≥2, ≤4)
- DEB_CYCLES, 1_000_000, consecutive stable samples required to accept a key level change (10 ms at 100 MHz; ≥2)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- wasde_signal  in  5  registered key levels: [4]=W, [3]=A, [2]=S, [1]=D, [0]=E; 1 = pressed
- play_done  in  1  single-cycle pulse from the player when the current song ends
- song_idx  out  SW  selected song, 0..NUM_SONGS-1
- mode  out  2  selected mode: 0=FREE, 1=AUTO, 2=LEARN
- play_start  out  1  single-cycle pulse: begin playing song_idx in mode
- play_stop  out  1  single-cycle pulse: abort playback
- paused  out  1  level, high while in PAUSED
- state  out  2  FSM state for display: 0=BROWSE, 1=PLAYING, 2=PAUSED

## Operation
- Debounce, per key: counter increments while the raw level differs from the debounced level.
  - Counter clears on any sample equal to the debounced level.
  - When the counter reaches DEB_CYCLES, the debounced level toggles and the counter clears.
- Press event: rising edge of the debounced level, exactly one cycle wide. Releases produce no event.
- Priority when several events occur in one cycle: E > W > S > A > D. Only the winner is acted on; the others are discarded.
- BROWSE:
  - W: song_idx−1, wraps 0→NUM_SONGS-1.
  - S: song_idx+1, wraps NUM_SONGS-1→0.
  - A: mode−1, wraps 0→NUM_MODES-1.
  - D: mode+1, wraps NUM_MODES-1→0.
  - E: pulse play_start, go to PLAYING.
  - play_done is ignored.
- PLAYING:
  - E: go to PAUSED.
  - W or S: pulse play_stop, go to BROWSE; song_idx unchanged.
  - A and D are ignored.
  - play_done in mode AUTO: song_idx+1 with wrap, pulse play_start, stay in PLAYING.
  - play_done in any other mode: go to BROWSE, no play_stop.
- PAUSED:
  - E: go to PLAYING (resume, no play_start).
  - W or S: pulse play_stop, go to BROWSE.
  - A, D and play_done are ignored.
- play_done and a key event in the same cycle while in PLAYING: play_done wins; the key event is dropped.
- mode and song_idx never take out-of-range values.

## Timing
- Reset values:
  - song_idx=0, mode=0, state=BROWSE.
  - play_start=0, play_stop=0, paused=0.
  - All debounced levels 0, all counters 0.
- Reset asserted mid-playback forces BROWSE immediately with no play_stop pulse.
- A key held through reset release is seen as a new press DEB_CYCLES samples after release.
- Key latency, with a key raw-high from sample edge 1 onward:
  - The debounced level rises at edge DEB_CYCLES.
  - The press event is high in the following cycle.
  - FSM outputs (song_idx, mode, state, paused) update at edge DEB_CYCLES+1.
  - play_start/play_stop are registered and high for the cycle after edge DEB_CYCLES+1.
- play_done to response: one edge; outputs update at the edge that samples play_done.
- A bounce shorter than DEB_CYCLES samples produces no event.
- Holding a key produces exactly one event (no auto-repeat).
- play_start and play_stop are never high in the same cycle.

## Structure
- Shared package pianista_pkg holds:
  - state encodings ST_BROWSE/ST_PLAYING/ST_PAUSED
  - mode encodings MODE_FREE/MODE_AUTO/MODE_LEARN
  - key bit indices KEY_W/KEY_A/KEY_S/KEY_D/KEY_E
- Sub-module key_debounce (parameter DEB_CYCLES; ports clk, rst, raw, level, press) is instantiated 5× in a generate loop.
- The FSM, wrap arithmetic and priority select live in song_select_ctrl.

## Test plan
All scenarios use DEB_CYCLES=4 and NUM_SONGS=8.
- Reset check: assert rst asynchronously mid-cycle with PLAYING active → state=0, song_idx=0, mode=0, paused=0 immediately; no play_stop pulse.
- Bounce filtering:
  - S pulsed high for 3 cycles → no change.
  - S held 4+ cycles → song_idx 0→1 at edge 5.
  - Held 100 cycles → exactly one increment.
- Wrap-around:
  - W from song_idx=0 → 7; S from 7 → 0.
  - D three times from mode=0 → 1, 2, 0.
  - A from 0 → 2.
- Playback sequence from BROWSE:
  - E → play_start one cycle, state=1.
  - E → state=2, paused=1.
  - E → state=1, no play_start.
  - S → play_stop one cycle, state=0, song_idx unchanged.
- AUTO mode, song_idx=7, play_done while PLAYING → song_idx=0, play_start pulse, state stays 1. Same with mode=FREE → state=0, no pulse.
- Simultaneous events:
  - E and S debounced high in the same cycle in BROWSE → play_start only, song_idx unchanged.
  - play_done coincident with E in PLAYING (mode FREE) → state=0, paused=0.
